// File: rtl/led_channel_array.sv
// LED channel array: shared prescaler/phase counter, per-channel OFF/ON/BLINK/PWM
// with one shadow slot whose contents commit only on a phase wrap or while disabled.
module led_channel_array #(
    parameter  int NUM_CH   = 6,
    parameter  int CNT_W    = 8,
    parameter  int PRESCALE = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CH_W:0]   CH_LIM  = (CH_W + 1)'(NUM_CH);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic              pend_v_q, pend_v_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [1:0]        pend_mode_q, pend_mode_d;
    logic [CNT_W-1:0]  pend_duty_q, pend_duty_d;
    logic [1:0]        mode_q [NUM_CH];
    logic [1:0]        mode_d [NUM_CH];
    logic [CNT_W-1:0]  duty_q [NUM_CH];
    logic [CNT_W-1:0]  duty_d [NUM_CH];
    logic              err_q, err_d;
    logic [NUM_CH-1:0] led_q, led_d;

    logic tick;
    logic wrap;
    logic accept;
    logic ch_ok;
    logic commit;

    always_comb begin
        tick   = en && (presc_q == PS_LAST);
        wrap   = tick && (&phase_q);
        accept = cfg_valid && !pend_v_q;
        ch_ok  = ({1'b0, cfg_ch} < CH_LIM);
        commit = pend_v_q && (wrap || !en);
    end

    // Disabled counters sit at zero so re-enabling restarts a clean period.
    always_comb begin
        presc_d = '0;
        phase_d = '0;
        if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            phase_d = tick ? phase_q + 1'b1 : phase_q;
        end
    end

    always_comb begin
        pend_v_d    = pend_v_q;
        pend_ch_d   = pend_ch_q;
        pend_mode_d = pend_mode_q;
        pend_duty_d = pend_duty_q;
        err_d       = accept && !ch_ok;
        if (commit) begin
            pend_v_d = 1'b0;
        end
        if (accept && ch_ok) begin
            pend_v_d    = 1'b1;
            pend_ch_d   = cfg_ch;
            pend_mode_d = cfg_mode;
            pend_duty_d = cfg_duty;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i] = mode_q[i];
            duty_d[i] = duty_q[i];
            if (commit && (pend_ch_q == CH_W'(i))) begin
                mode_d[i] = pend_mode_q;
                duty_d[i] = pend_duty_q;
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = phase_q[CNT_W-1];
                MODE_PWM:   led_d[i] = (phase_q < duty_q[i]);
                default:    led_d[i] = 1'b0;
            endcase
        end
        if (!en) begin
            led_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            phase_q     <= '0;
            pend_v_q    <= 1'b0;
            pend_ch_q   <= '0;
            pend_mode_q <= MODE_OFF;
            pend_duty_q <= '0;
            err_q       <= 1'b0;
            led_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_OFF;
                duty_q[i] <= '0;
            end
        end else begin
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            pend_v_q    <= pend_v_d;
            pend_ch_q   <= pend_ch_d;
            pend_mode_q <= pend_mode_d;
            pend_duty_q <= pend_duty_d;
            err_q       <= err_d;
            led_q       <= led_d;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= mode_d[i];
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign cfg_ready = !pend_v_q;
    assign cfg_err   = err_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_channel_array.sv
// Bench for led_channel_array: directed config writes, expectations queued
// per cycle and popped by a negedge monitor.
module tb_led_channel_array;

    localparam int K_LED = 0;
    localparam int K_RDY = 1;
    localparam int K_ERR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [3:0] cfg_duty = '0;
    logic       cfg_err;
    logic [5:0] led;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] exp;
        logic [63:0] msk;
        string       name;
    } sb_t;

    sb_t sbq[$];

    led_channel_array #(
        .NUM_CH   (6),
        .CNT_W    (4),
        .PRESCALE (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_duty  (cfg_duty),
        .cfg_err   (cfg_err),
        .led       (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int kind,
                             input logic [63:0] exp,
                             input logic [63:0] msk,
                             input string name);
        sb_t e;
        e.cyc  = c;
        e.kind = kind;
        e.exp  = exp;
        e.msk  = msk;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        sb_t         rest[$];
        logic [63:0] act;
        rest = {};
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) begin
                case (sbq[i].kind)
                    K_LED:   act = {58'b0, led};
                    K_RDY:   act = {63'b0, cfg_ready};
                    default: act = {63'b0, cfg_err};
                endcase
                n_total++;
                if ((act & sbq[i].msk) == sbq[i].exp) n_pass++;
                else $display("FAIL %s @%0d: got %h expected %h",
                              sbq[i].name, cyc, act & sbq[i].msk, sbq[i].exp);
            end else if (sbq[i].cyc < cyc) begin
                n_total++;
                $display("FAIL %s: expectation for cycle %0d not reached",
                         sbq[i].name, sbq[i].cyc);
            end else begin
                rest.push_back(sbq[i]);
            end
        end
        sbq = rest;
    end

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, K_LED, 64'h0, 64'h3F, "rst_led");
        expect_at(cyc + 1, K_RDY, 64'h1, 64'h1, "rst_ready");
        expect_at(cyc + 1, K_ERR, 64'h0, 64'h1, "rst_err");
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic cfg_write(input int ch, input logic [1:0] mode,
                             input logic [3:0] duty,
                             output int acc, output int waited);
        logic bad;
        bad       = (ch >= 6);
        waited    = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch[2:0];
        cfg_mode  = mode;
        cfg_duty  = duty;
        while (!cfg_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        acc = cyc;
        if (!cfg_ready) begin
            n_total++;
            $display("FAIL write_ch%0d: cfg_ready stuck low", ch);
        end else begin
            expect_at(acc + 1, K_ERR, {63'b0, bad}, 64'h1, "err_pulse");
            expect_at(acc + 2, K_ERR, 64'h0, 64'h1, "err_clear");
            expect_at(acc + 1, K_RDY, {63'b0, bad}, 64'h1, "ready_after_acc");
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n0);
        int w;
        w = 0;
        while (!cfg_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        n0 = cyc;
        if (!cfg_ready) begin
            n_total++;
            $display("FAIL wait_ready: commit not seen");
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations pending", sbq.size());
        end
    endtask

    initial begin
        int c, acc, acc2, w, n0;
        logic [5:0] e;

        @(negedge clk);

        // idle: nothing configured
        do_reset();
        c = cyc;
        for (int k = 1; k <= 100; k++)
            expect_at(c + k, K_LED, 64'h0, 64'h3F, "idle_led");
        expect_at(c + 1, K_RDY, 64'h1, 64'h1, "idle_ready");
        expect_at(c + 50, K_RDY, 64'h1, 64'h1, "idle_ready");
        expect_at(c + 100, K_RDY, 64'h1, 64'h1, "idle_ready");
        expect_at(c + 2, K_ERR, 64'h0, 64'h1, "idle_err");
        expect_at(c + 60, K_ERR, 64'h0, 64'h1, "idle_err");
        drain();

        // ch2 PWM duty 4
        do_reset();
        cfg_write(2, 2'd3, 4'd4, acc, w);
        expect_at(acc + 15, K_RDY, 64'h0, 64'h1, "t2_ready_low");
        expect_at(acc + 31, K_RDY, 64'h0, 64'h1, "t2_ready_low");
        wait_ready(n0);
        chk("t2_commit_latency", n0 - acc, 32);
        for (int j = 0; j < 64; j++) begin
            e = ((j % 32) < 8) ? 6'h04 : 6'h00;
            expect_at(n0 + 1 + j, K_LED, {58'b0, e}, 64'h3F, "t2_pwm");
        end
        drain();

        // ch0 BLINK, ch5 ON stalled behind it, then an invalid channel
        do_reset();
        cfg_write(0, 2'd2, 4'd0, acc, w);
        cfg_write(5, 2'd1, 4'd0, acc2, w);
        chk("t3_stall_cycles", w, 31);
        n0 = acc2;
        for (int j = 1; j < 64; j++) begin
            e = {(j >= 32), 4'b0, ((j % 32) >= 16)};
            expect_at(n0 + 1 + j, K_LED, {58'b0, e}, 64'h3F, "t3_blink_on");
        end
        expect_at(n0 + 31, K_RDY, 64'h0, 64'h1, "t3_ready_low");
        expect_at(n0 + 32, K_RDY, 64'h1, 64'h1, "t3_ready_back");
        cfg_write(7, 2'd1, 4'd0, acc, w);
        chk("t4_bad_accept_cycle", acc, n0 + 32);
        drain();

        // ch1 duty 0, duty 15, ON, then OFF mid-period
        do_reset();
        cfg_write(1, 2'd3, 4'd0, acc, w);
        wait_ready(n0);
        for (int k = 1; k <= 100; k++) begin
            if (k <= 32)      e = 6'h00;
            else if (k <= 64) e = ((k - 33) < 30) ? 6'h02 : 6'h00;
            else if (k <= 96) e = 6'h02;
            else              e = 6'h00;
            expect_at(n0 + k, K_LED, {58'b0, e}, 64'h3F, "t5_ch1");
        end
        cfg_write(1, 2'd3, 4'd15, acc, w);
        cfg_write(1, 2'd1, 4'd0, acc, w);
        repeat (47) @(negedge clk);
        cfg_write(1, 2'd0, 4'd0, acc, w);
        chk("t5_off_accept_cycle", acc, n0 + 80);
        drain();

        // en drop with pending write, restart, then reset mid-period
        do_reset();
        cfg_write(3, 2'd3, 4'd1, acc, w);
        wait_ready(n0);
        for (int k = 1; k <= 7; k++) begin
            e = (k <= 2) ? 6'h08 : 6'h00;
            expect_at(n0 + k, K_LED, {58'b0, e}, 64'h3F, "t6_pre");
        end
        for (int k = 8; k <= 10; k++)
            expect_at(n0 + k, K_LED, 64'h0, 64'h3F, "t6_en_low_led");
        for (int j = 0; j <= 40; j++) begin
            e = ((j % 32) < 2) ? 6'h18 : 6'h10;
            expect_at(n0 + 11 + j, K_LED, {58'b0, e}, 64'h3F, "t6_restart");
        end
        expect_at(n0 + 3, K_RDY, 64'h0, 64'h1, "t6_pending");
        expect_at(n0 + 7, K_RDY, 64'h0, 64'h1, "t6_pending");
        expect_at(n0 + 8, K_RDY, 64'h1, 64'h1, "t6_commit_on_en_low");
        cfg_write(4, 2'd1, 4'd0, acc, w);
        repeat (6) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        drain();
        cfg_write(0, 2'd1, 4'd0, acc, w);
        c = cyc;
        rst = 1'b1;
        expect_at(c + 1, K_LED, 64'h0, 64'h3F, "t6_rst_led");
        expect_at(c + 1, K_RDY, 64'h1, 64'h1, "t6_rst_ready");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 2; k <= 70; k++)
            expect_at(c + k, K_LED, 64'h0, 64'h3F, "t6_post_rst_led");
        expect_at(c + 40, K_RDY, 64'h1, 64'h1, "t6_post_rst_ready");
        expect_at(c + 70, K_RDY, 64'h1, 64'h1, "t6_post_rst_ready");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
